// File: rtl/multiplier_32.sv
// multiplier_32 -- sequential 32x32 -> 64 shift-add multiplier.
//
// Retires one multiplier bit per enabled clock. Operands are captured on an
// accepted start, and the product is held with dne high until the next
// accepted start.
//
// Optional feature: define MULTIPLIER_32_SIGNED_EN for two's-complement
// operands. Magnitudes are multiplied and a NEG state restores the sign, which
// adds one cycle of latency.
//
// Ports:
//   clk    in   1   rising-edge clock
//   rst_n  in   1   asynchronous active-low reset
//   ena    in   1   clock enable; all state frozen while low
//   start  in   1   begin multiply (accepted in IDLE, or in DONE once dne=1)
//   a      in  32   multiplicand
//   b      in  32   multiplier
//   p      out 64   product, valid while dne=1
//   dne    out  1   product valid, held until next accepted start
//   busy   out  1   operation in progress
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | reset state, waiting for start
// RUN   | 32 shift-add iterations, cnt 0..31
// NEG   | sign fix-up of the accumulator (signed build only)
// DONE  | first enabled cycle latches p and raises dne; then holds the result

module multiplier_32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] p,
  output logic        dne,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_NEG  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplr_q,  mplr_d;
  logic [63:0] acc_q,   acc_d;
  logic [5:0]  cnt_q,   cnt_d;
  logic [63:0] p_q,     p_d;
  logic        dne_q,   dne_d;
  logic        busy_q,  busy_d;

`ifdef MULTIPLIER_32_SIGNED_EN
  logic        neg_q, neg_d;
  logic [31:0] a_mag, b_mag;
`endif

  logic        accept;
  logic [32:0] sum;

  // DONE accepts a new start only after the result has been latched (dne=1).
  // Before that, the operation is still busy.
  assign accept = ena && start &&
                  ((state_q == S_IDLE) || ((state_q == S_DONE) && dne_q));

  // Upper half of the accumulator plus the multiplicand when the current
  // multiplier bit is set; the carry becomes the new MSB after the shift.
  assign sum = {1'b0, acc_q[63:32]} + {1'b0, (mplr_q[0] ? mcand_q : 32'd0)};

`ifdef MULTIPLIER_32_SIGNED_EN
  // |-2^31| wraps to 0x80000000, which is correct as an unsigned magnitude.
  assign a_mag = a[31] ? (~a + 32'd1) : a;
  assign b_mag = b[31] ? (~b + 32'd1) : b;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mcand_q <= 32'd0;
      mplr_q  <= 32'd0;
      acc_q   <= 64'd0;
      cnt_q   <= 6'd0;
      p_q     <= 64'd0;
      dne_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef MULTIPLIER_32_SIGNED_EN
      neg_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      dne_q   <= dne_d;
      busy_q  <= busy_d;
`ifdef MULTIPLIER_32_SIGNED_EN
      neg_q   <= neg_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (ena) begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (accept) state_d = S_RUN;
        end
        S_RUN: begin
          if (cnt_q == 6'd31) begin
`ifdef MULTIPLIER_32_SIGNED_EN
            state_d = S_NEG;
`else
            state_d = S_DONE;
`endif
          end
        end
        S_NEG:   state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath and flag updates
  always_comb begin
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    dne_d   = dne_q;
    busy_d  = busy_q;
`ifdef MULTIPLIER_32_SIGNED_EN
    neg_d   = neg_q;
`endif
    if (accept) begin
`ifdef MULTIPLIER_32_SIGNED_EN
      mcand_d = a_mag;
      mplr_d  = b_mag;
      neg_d   = a[31] ^ b[31];
`else
      mcand_d = a;
      mplr_d  = b;
`endif
      acc_d   = 64'd0;
      cnt_d   = 6'd0;
      dne_d   = 1'b0;
      busy_d  = 1'b1;
    end else if (ena) begin
      case (state_q)
        S_RUN: begin
          acc_d  = {sum, acc_q[31:1]};
          mplr_d = {1'b0, mplr_q[31:1]};
          cnt_d  = cnt_q + 6'd1;
        end
        S_NEG: begin
`ifdef MULTIPLIER_32_SIGNED_EN
          if (neg_q) acc_d = ~acc_q + 64'd1;
`endif
        end
        S_DONE: begin
          if (!dne_q) begin
            p_d    = acc_q;
            dne_d  = 1'b1;
            busy_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    p    = p_q;
    dne  = dne_q;
    busy = busy_q;
  end

endmodule

// File: tb/tb_multiplier_32.sv
module tb_multiplier_32;

  logic        clk = 1'b0;
  logic        rst_n, ena, start;
  logic [31:0] a, b;
  logic [63:0] p;
  logic        dne, busy;

  int n_cmp  = 0;
  int n_fail = 0;
  int edge_cnt = 0;
  int e0 = 0;
  logic [63:0] sb[$];

`ifdef MULTIPLIER_32_SIGNED_EN
  localparam int LAT = 34;
`else
  localparam int LAT = 33;
`endif

  multiplier_32 dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start),
    .a(a), .b(b), .p(p), .dne(dne), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y);
    logic [63:0] xe, ye;
`ifdef MULTIPLIER_32_SIGNED_EN
    xe = {{32{x[31]}}, x};
    ye = {{32{y[31]}}, y};
`else
    xe = {32'd0, x};
    ye = {32'd0, y};
`endif
    return xe * ye;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Drive an accepted start; E0 is the edge that samples it.
  task automatic start_op(input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    a = x; b = y; ena = 1'b1; start = 1'b1;
    sb.push_back(model(x, y));
    @(posedge clk);
    #1;
    start = 1'b0;
    e0 = edge_cnt;
    check("busy_after_e0", {63'd0, busy}, 64'd1);
    check("dne_after_e0",  {63'd0, dne},  64'd0);
  endtask

  // Wait (bounded) for dne, then check wall-clock latency and product.
  task automatic wait_done(input string tag, input int exp_lat);
    int n;
    logic [63:0] exp_p;
    n = 0;
    while (!dne && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_timeout"}, {63'd0, dne}, 64'd1);
    check({tag, "_latency"}, 64'(edge_cnt - e0), 64'(exp_lat));
    check({tag, "_busy_low"}, {63'd0, busy}, 64'd0);
    exp_p = sb.pop_front();
    check({tag, "_p"}, p, exp_p);
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b0; start = 1'b0; a = '0; b = '0;
    #1;
    check("rst_p",    p,             64'd0);
    check("rst_dne",  {63'd0, dne},  64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ena   = 1'b1;

    // Basic unsigned; busy must still be high one edge before completion.
    start_op(32'd7, 32'd6);
    repeat (LAT - 1) @(posedge clk);
    #1;
    check("7x6_busy_before_done", {63'd0, busy}, 64'd1);
    check("7x6_dne_before_done",  {63'd0, dne},  64'd0);
    wait_done("7x6", LAT);

    // Max operands, then back-to-back restart from DONE.
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("max", LAT);
    start_op(32'h1234_5678, 32'd0);
    wait_done("b2b_zero", LAT);

    // Stall 5 cycles mid-RUN, plus an ignored start during RUN.
    start_op(32'd3, 32'd5);
    repeat (9) @(posedge clk);
    @(negedge clk);
    ena = 1'b0;
    repeat (5) @(negedge clk);
    ena = 1'b1;
    check("stall_dne_low", {63'd0, dne}, 64'd0);
    a = 32'd9; b = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ignored_start_busy", {63'd0, busy}, 64'd1);
    wait_done("stall_3x5", LAT + 5);

    // Reset mid-operation, then restart.
    start_op(32'd100, 32'd100);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_p",    p,             64'd0);
    check("midrst_dne",  {63'd0, dne},  64'd0);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    void'(sb.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    start_op(32'd100, 32'd100);
    wait_done("100x100", LAT);

`ifdef MULTIPLIER_32_SIGNED_EN
    start_op(-32'sd3, 32'd5);
    wait_done("s_m3x5", LAT);
    start_op(32'h8000_0000, 32'h8000_0000);
    wait_done("s_min", LAT);
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("s_m1xm1", LAT);
`endif

    // A few random operand pairs.
    for (int i = 0; i < 4; i++) begin
      start_op($urandom, $urandom);
      wait_done("rand", LAT);
    end

    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/multiplier_32.md
# multiplier_32

Sequential 32×32→64 shift-add multiplier, the multiply counterpart to the datapath's sequential divider. It sits beside the divider in the execute stage and is driven by the same controller. It uses the same `ena` clock-enable convention and the same done-flag convention. Operands are captured on `start`, one multiplier bit is retired per enabled cycle, and the 64-bit product is held with `dne` high until the next start.

## Interface
- No parameters; width is fixed at 32-bit operands and a 64-bit product.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `ena`  in  1  clock enable; when low, all state is frozen (including `start` sampling)
- `start`  in  1  begin multiply; sampled only when `ena`=1 and not busy
- `a`  in  32  multiplicand, captured on accepted start
- `b`  in  32  multiplier, captured on accepted start
- `p`  out  64  product; valid while `dne`=1
- `dne`  out  1  product valid; held until next accepted start
- `busy`  out  1  operation in progress (RUN or NEG state)

## Operation
- States:
  - IDLE (after reset)
  - RUN: 32 iterations, 6-bit counter 0..31
  - NEG: only with the macro enabled
  - DONE
- Accepted start (`ena`=1, `start`=1, state IDLE or DONE):
  - mcand←a, mplr←b, acc←0, cnt←0, `dne`←0, `busy`←1, go to RUN.
- RUN, per enabled cycle:
  - If mplr[0], {c,acc[63:32]} ← acc[63:32]+mcand (33-bit sum); else c←0.
  - Then {c,acc} is shifted right 1 into acc; mplr shifts right 1; cnt++.
- RUN exit: after the cycle with cnt=31, go to DONE (or NEG if compiled in); no overflow is possible.
- DONE: p←acc, `dne`←1, `busy`←0. `p` and `dne` hold until the next accepted start.
- `start` during RUN/NEG is ignored; there is no queueing and captured operands are unaffected.
- Operand changes after capture have no effect.
- Latency is fixed regardless of operand values; there is no early exit on zero.
- Reset values: `p`=0, `dne`=0, `busy`=0, state IDLE, internal registers 0.

## Timing
- Start accepted at enabled edge E0 → `busy`=1 after E0.
- Unsigned build: `dne`=1 and `p` valid after enabled edge E33; `busy` falls at the same edge.
- Signed build: the same events occur at E34 (one NEG cycle).
- `ena`=0 cycles are not counted. Each one delays completion by exactly one clock, and outputs hold.
- Back-to-back: start asserted in DONE is accepted; `dne` drops the next edge and the new result follows 33 (34) enabled edges later.
- `rst_n` low at any time, including mid-RUN: immediate async return to reset values. After `rst_n` rises, the first enabled edge may accept a start.
- Start and reset deassertion on the same edge: the start is accepted only if `rst_n` was already high before that edge.

## Configuration
- `MULTIPLIER_32_SIGNED_EN` defined: operands are two's complement.
  - On capture: mcand←|a|, mplr←|b|, neg←a[31]^b[31]. |−2³¹| = 0x80000000, treated as unsigned.
  - Extra NEG state after RUN: if neg, acc←−acc (64-bit two's complement).
  - Latency is 34.
- Undefined: operands and product are unsigned; there is no NEG state; latency is 33.

## Test plan
- Unsigned: a=7, b=6, start at E0 → `busy` E0–E32, `dne`=1 after E33, `p`=0x000000000000002A.
- Unsigned max: a=b=0xFFFFFFFF → `p`=0xFFFFFFFE00000001. Next, a=0x12345678, b=0 restarted from DONE → `dne` low for 33 cycles, then `p`=0.
- Stall and ignore:
  - Start a=3, b=5.
  - Hold `ena`=0 for 5 cycles mid-RUN → `dne` at E38 (wall-clock), `p`=15.
  - `start` with a=9, b=9 during RUN → ignored, `p` still 15.
- Reset mid-op: start a=100, b=100, drop `rst_n` at cycle 10 → `p`=0, `dne`=0, `busy`=0 immediately. Restart a=100, b=100 → `p`=10000 after 33 cycles.
- Signed (macro defined):
  - a=−3, b=5 → `p`=0xFFFFFFFFFFFFFFF1 after E34.
  - a=b=0x80000000 → `p`=0x4000000000000000.
  - a=−1, b=−1 → `p`=1.
